// File: rtl/matmul_seq.sv
// Sequential unsigned N x N matrix multiply (C = A*B or C += A*B) using one MAC per cycle.
// Define MATMUL_SAT_EN to saturate each result element at 2^DW-1 instead of wrapping modulo 2^DW.
//   state  | meaning
//   S_IDLE | waiting for start; operands and acc_mode captured on acceptance
//   S_CALC | one MAC per cycle, k innermost, then j, then i
//   S_DONE | one-cycle done pulse, mat_c coherent
module matmul_seq #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          acc_mode,
  input  logic [N-1:0][N-1:0][DW-1:0]   mat_a,
  input  logic [N-1:0][N-1:0][DW-1:0]   mat_b,
  output logic [N-1:0][N-1:0][DW-1:0]   mat_c,
  output logic                          busy,
  output logic                          done
);

  localparam int CW = $clog2(N);
  localparam int AW = 2*DW + $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N-1);
  localparam logic [AW-1:0] MAXV = AW'({DW{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        r_state;
  logic [N-1:0][N-1:0][DW-1:0]   r_a;
  logic [N-1:0][N-1:0][DW-1:0]   r_b;
  logic [N-1:0][N-1:0][DW-1:0]   r_c;
  logic                          r_acc_mode;
  logic                          r_busy;
  logic                          r_done;
  logic [CW-1:0]                 r_i;
  logic [CW-1:0]                 r_j;
  logic [CW-1:0]                 r_k;
  logic [AW-1:0]                 r_acc;

  logic [2*DW-1:0]               w_prod;
  logic [AW-1:0]                 w_base;
  logic [AW-1:0]                 w_sum;
  logic [DW-1:0]                 w_res;

  // k=0 seeds the running sum from the previous result (accumulate) or zero
  always_comb begin
    w_prod = r_a[r_i][r_k] * r_b[r_k][r_j];
    if (r_k == '0) begin
      w_base = r_acc_mode ? AW'(r_c[r_i][r_j]) : '0;
    end else begin
      w_base = r_acc;
    end
    w_sum = w_base + AW'(w_prod);
`ifdef MATMUL_SAT_EN
    w_res = (w_sum > MAXV) ? {DW{1'b1}} : w_sum[DW-1:0];
`else
    w_res = w_sum[DW-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_acc_mode <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_acc      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a        <= mat_a;
            r_b        <= mat_b;
            r_acc_mode <= acc_mode;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_k == LAST) begin
            r_c[r_i][r_j] <= w_res;
            r_acc         <= '0;
            r_k           <= '0;
            if (r_j == LAST) begin
              r_j <= '0;
              if (r_i == LAST) begin
                r_i     <= '0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_acc <= w_sum;
            r_k   <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mat_c = r_c;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: N=2 and N=3 instances checked against a plain-arithmetic matrix model.
module tb_matmul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic s2, m2, bz2, dn2;
  logic [1:0][1:0][7:0] a2, b2, c2;
  logic s3, m3, bz3, dn3;
  logic [2:0][2:0][7:0] a3, b3, c3;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ma[3][3];
  int mb[3][3];
  int mdl[2][3][3];

  always #5 clk = ~clk;

  matmul_seq #(.N(2), .DW(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .acc_mode(m2),
    .mat_a(a2), .mat_b(b2), .mat_c(c2), .busy(bz2), .done(dn2)
  );

  matmul_seq #(.N(3), .DW(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3), .acc_mode(m3),
    .mat_a(a3), .mat_b(b3), .mat_c(c3), .busy(bz3), .done(dn3)
  );

  function automatic int reduce(input longint s);
`ifdef MATMUL_SAT_EN
    return (s > 255) ? 255 : int'(s);
`else
    return int'(s % 256);
`endif
  endfunction

  task automatic model_op(input int n, input bit acc);
    longint s;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = acc ? longint'(mdl[n-2][i][j]) : 0;
        for (int k = 0; k < n; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
        mdl[n-2][i][j] = reduce(s);
      end
  endtask

  task automatic model_clear();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) mdl[w][i][j] = 0;
  endtask

  task automatic load_ops();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a3[i][j] = 8'(ma[i][j]);
        b3[i][j] = 8'(mb[i][j]);
        if (i < 2 && j < 2) begin
          a2[i][j] = 8'(ma[i][j]);
          b2[i][j] = 8'(mb[i][j]);
        end
      end
  endtask

  task automatic rand_ops(input int lo);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma[i][j] = int'($urandom_range(255, lo));
        mb[i][j] = int'($urandom_range(255, lo));
      end
  endtask

  function automatic logic [7:0] get_c(input int n, input int i, input int j);
    if (n == 2) return c2[i][j];
    return c3[i][j];
  endfunction

  // Starts one operation and watches N^3+3 cycles; poke re-pulses start with new operands mid-run.
  task automatic run_op(input int n, input bit acc, input bit poke,
                        output int first_done, output int ndone, output bit busy_ok);
    int last;
    logic d, b;
    last = n * n * n;
    @(negedge clk);
    load_ops();
    if (n == 2) begin m2 = acc; s2 = 1'b1; end
    else begin m3 = acc; s3 = 1'b1; end
    @(posedge clk); #1;
    s2 = 1'b0; s3 = 1'b0;
    busy_ok = (n == 2) ? (bz2 === 1'b1) : (bz3 === 1'b1);
    first_done = -1;
    ndone = 0;
    for (int cyc = 1; cyc <= last + 3; cyc++) begin
      @(posedge clk); #1;
      d = (n == 2) ? dn2 : dn3;
      b = (n == 2) ? bz2 : bz3;
      if (d === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = cyc;
      end
      if (b !== (cyc <= last)) busy_ok = 1'b0;
      if (poke && n == 2 && (cyc == 2 || cyc == 4)) begin
        a2 = $urandom;
        b2 = $urandom;
        m2 = ~m2;
        s2 = 1'b1;
      end else begin
        s2 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    s2 = 0; m2 = 0; a2 = '0; b2 = '0;
    s3 = 0; m3 = 0; a3 = '0; b3 = '0;
    rst_n = 1'b0;
    model_clear();
    #12;
    vec_cnt++;
    if (bz2 !== 1'b0 || dn2 !== 1'b0 || bz3 !== 1'b0 || dn3 !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_flags got busy=%b/%b done=%b/%b want 0", bz2, bz3, dn2, dn3);
    end
    vec_cnt++;
    if (c2 !== '0 || c3 !== '0) begin
      err_cnt++;
      $display("FAIL reset_matc got %h / %h want 0", c2, c3);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (bz2 !== 1'b0 || dn2 !== 1'b0 || c2 !== '0) begin
      err_cnt++;
      $display("FAIL idle_after_reset got busy=%b done=%b c=%h want 0", bz2, dn2, c2);
    end
  endtask

  task automatic test_basic();
    int fd, nd;
    bit bok;
    bit acc_tab[3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] want_tab[3] = '{8'd16, 8'd32, 8'd16};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin ma[i][j] = 2; mb[i][j] = 4; end
      run_op(2, acc_tab[t], 1'b0, fd, nd, bok);
      model_op(2, acc_tab[t]);
      vec_cnt++;
      if (fd !== 8 || nd !== 1 || !bok) begin
        err_cnt++;
        $display("FAIL basic%0d_timing got done_at=%0d pulses=%0d busy_ok=%0d want 8/1/1", t, fd, nd, bok);
      end
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          vec_cnt++;
          if (c2[i][j] !== want_tab[t] || c2[i][j] !== 8'(mdl[0][i][j])) begin
            err_cnt++;
            $display("FAIL basic%0d_c[%0d][%0d] got %0d want %0d", t, i, j, c2[i][j], want_tab[t]);
          end
        end
    end
  endtask

  task automatic test_overflow();
    int fd, nd;
    bit bok;
    logic [7:0] want;
`ifdef MATMUL_SAT_EN
    want = 8'd255;
`else
    want = 8'd128;
`endif
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin ma[i][j] = 200; mb[i][j] = 200; end
    run_op(2, 1'b0, 1'b0, fd, nd, bok);
    model_op(2, 1'b0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        vec_cnt++;
        if (c2[i][j] !== want || c2[i][j] !== 8'(mdl[0][i][j])) begin
          err_cnt++;
          $display("FAIL overflow_c[%0d][%0d] got %0d want %0d", i, j, c2[i][j], want);
        end
      end
  endtask

  task automatic test_n3();
    int fd, nd;
    bit bok;
    int sq[3][3] = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          ma[i][j] = 3 * i + j + 1;
          mb[i][j] = (pass == 0) ? ((i == j) ? 1 : 0) : ma[i][j];
        end
      run_op(3, 1'b0, 1'b0, fd, nd, bok);
      model_op(3, 1'b0);
      vec_cnt++;
      if (fd !== 27 || nd !== 1 || !bok) begin
        err_cnt++;
        $display("FAIL n3_%0d_timing got done_at=%0d pulses=%0d busy_ok=%0d want 27/1/1", pass, fd, nd, bok);
      end
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          vec_cnt++;
          if (c3[i][j] !== 8'((pass == 0) ? ma[i][j] : sq[i][j]) || c3[i][j] !== 8'(mdl[1][i][j])) begin
            err_cnt++;
            $display("FAIL n3_%0d_c[%0d][%0d] got %0d want %0d", pass, i, j, c3[i][j], mdl[1][i][j]);
          end
        end
    end
  endtask

  task automatic test_start_while_busy();
    int fd, nd;
    bit bok;
    rand_ops(0);
    run_op(2, 1'b0, 1'b1, fd, nd, bok);
    model_op(2, 1'b0);
    vec_cnt++;
    if (fd !== 8 || nd !== 1 || !bok) begin
      err_cnt++;
      $display("FAIL busy_start_timing got done_at=%0d pulses=%0d busy_ok=%0d want 8/1/1", fd, nd, bok);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        vec_cnt++;
        if (c2[i][j] !== 8'(mdl[0][i][j])) begin
          err_cnt++;
          $display("FAIL busy_start_c[%0d][%0d] got %0d want %0d", i, j, c2[i][j], mdl[0][i][j]);
        end
      end
  endtask

  task automatic test_random();
    int fd, nd, n;
    bit bok, acc;
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(3, 2));
      acc = 1'($urandom_range(1, 0));
      rand_ops(0);
      run_op(n, acc, 1'b0, fd, nd, bok);
      model_op(n, acc);
      vec_cnt++;
      if (fd !== n * n * n || nd !== 1 || !bok) begin
        err_cnt++;
        $display("FAIL rand%0d_timing got done_at=%0d pulses=%0d busy_ok=%0d want %0d/1/1", t, fd, nd, bok, n * n * n);
      end
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) begin
          vec_cnt++;
          if (get_c(n, i, j) !== 8'(mdl[n-2][i][j])) begin
            err_cnt++;
            $display("FAIL rand%0d_n%0d_acc%0d_c[%0d][%0d] got %0d want %0d", t, n, acc, i, j, get_c(n, i, j), mdl[n-2][i][j]);
          end
        end
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    int exp1[2][2];
    logic [1:0][1:0][7:0] snap;
    rand_ops(0);
    model_op(2, 1'b1);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) exp1[i][j] = mdl[0][i][j];
    model_op(2, 1'b1);
    d1 = -1; d2 = -1; snap = '0;
    @(negedge clk);
    load_ops();
    m2 = 1'b1; s2 = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (dn2 === 1'b1) begin
        if (d1 < 0) begin d1 = cyc; snap = c2; end
        else if (d2 < 0) d2 = cyc;
      end
      if (cyc == 18) s2 = 1'b0;
    end
    s2 = 1'b0;
    vec_cnt++;
    if (d1 !== 8 || d2 !== 18) begin
      err_cnt++;
      $display("FAIL b2b_timing got done_at=%0d,%0d want 8,18", d1, d2);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        vec_cnt++;
        if (snap[i][j] !== 8'(exp1[i][j]) || c2[i][j] !== 8'(mdl[0][i][j])) begin
          err_cnt++;
          $display("FAIL b2b_c[%0d][%0d] got %0d,%0d want %0d,%0d", i, j, snap[i][j], c2[i][j], exp1[i][j], mdl[0][i][j]);
        end
      end
  endtask

  task automatic test_reset_mid();
    int fd, nd;
    bit bok, saw_done;
    rand_ops(1);
    run_op(2, 1'b0, 1'b0, fd, nd, bok);
    model_op(2, 1'b0);
    rand_ops(1);
    @(negedge clk);
    load_ops();
    m2 = 1'b0; s2 = 1'b1;
    @(posedge clk); #1;
    s2 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (c2 !== '0 || bz2 !== 1'b0 || dn2 !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid got c=%h busy=%b done=%b want 0", c2, bz2, dn2);
    end
    model_clear();
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dn2 !== 1'b0 || bz2 !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (dn2 !== 1'b0 || bz2 !== 1'b0) saw_done = 1'b1;
    end
    vec_cnt++;
    if (saw_done) begin
      err_cnt++;
      $display("FAIL reset_mid_no_done got activity after reset want none");
    end
    rand_ops(0);
    run_op(2, 1'b0, 1'b0, fd, nd, bok);
    model_op(2, 1'b0);
    vec_cnt++;
    if (fd !== 8 || nd !== 1 || !bok) begin
      err_cnt++;
      $display("FAIL reset_mid_rerun_timing got done_at=%0d pulses=%0d busy_ok=%0d want 8/1/1", fd, nd, bok);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        vec_cnt++;
        if (c2[i][j] !== 8'(mdl[0][i][j])) begin
          err_cnt++;
          $display("FAIL reset_mid_rerun_c[%0d][%0d] got %0d want %0d", i, j, c2[i][j], mdl[0][i][j]);
        end
      end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_n3();
    test_start_while_busy();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
